// File: rtl/jtag_uart_bus_arbiter_pkg.sv
// Shared JTAG-UART Avalon register map, field positions and arbiter state encodings.
package jtag_uart_bus_arbiter_pkg;

  localparam logic JUART_ADDR_DATA = 1'b0;
  localparam logic JUART_ADDR_CTRL = 1'b1;

  localparam int unsigned RVALID_BIT  = 15;
  localparam int unsigned WSPACE_LSB  = 16;
  localparam int unsigned WSPACE_MSB  = 31;
  localparam int unsigned RAVAIL_LSB  = 16;
  localparam int unsigned RAVAIL_MSB  = 31;
  localparam int unsigned RXDATA_MSB  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RX_RD  = 2'd1,
    TX_CHK = 2'd2,
    TX_WR  = 2'd3
  } arbState_t;

  // Free write-FIFO space reported in the control register.
  function automatic logic [15:0] wspaceOf(input logic [31:0] ctrlWord);
    return ctrlWord[WSPACE_MSB:WSPACE_LSB];
  endfunction

endpackage

// File: rtl/jtag_uart_bus_arbiter.sv
// Round-robin sharing of the JTAG-UART Avalon slave between the RX poller and the TX reply path.
// TX checks write-FIFO space first so a full host FIFO never blocks RX polling.
module jtag_uart_bus_arbiter
  import jtag_uart_bus_arbiter_pkg::*;
#(
  parameter int unsigned TX_SPACE_RETRY_GAP = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iRX_REQ,
  output logic        oRX_DONE,
  output logic [7:0]  oRX_DATA,
  output logic        oRX_VALID,
  input  logic        iTX_REQ,
  input  logic [7:0]  iTX_DATA,
  output logic        oTX_BUSY,
  output logic        oTX_DONE,
  output logic        oJTAG_SLAVE_ADDR,
  output logic        oJTAG_SLAVE_RDREQ,
  input  logic [31:0] iJTAG_SLAVE_RDDATA,
  output logic        oJTAG_SLAVE_WRREQ,
  output logic [31:0] oJTAG_SLAVE_WRDATA,
  input  logic        iJTAG_SLAVE_WAIT
);

  localparam int unsigned GAP_W = 16;

  arbState_t        state;
  logic             lastTx;
  logic             txPending;
  logic [7:0]       txByte;
  logic [GAP_W-1:0] gapCnt;
  logic             txEligible_c;
  logic             unusedRdBits;

  assign txEligible_c = txPending && (gapCnt == '0);
  assign unusedRdBits = ^iJTAG_SLAVE_RDDATA[RVALID_BIT-1:RXDATA_MSB+1];

  // Arbiter, bus FSM, TX acceptance and retry-gap counter.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state              <= IDLE;
      lastTx             <= 1'b1;
      txPending          <= 1'b0;
      txByte             <= '0;
      gapCnt             <= '0;
      oRX_DONE           <= 1'b0;
      oRX_DATA           <= '0;
      oRX_VALID          <= 1'b0;
      oTX_BUSY           <= 1'b0;
      oTX_DONE           <= 1'b0;
      oJTAG_SLAVE_ADDR   <= JUART_ADDR_DATA;
      oJTAG_SLAVE_RDREQ  <= 1'b0;
      oJTAG_SLAVE_WRREQ  <= 1'b0;
      oJTAG_SLAVE_WRDATA <= '0;
    end else begin
      oRX_DONE <= 1'b0;
      oTX_DONE <= 1'b0;

      if (gapCnt != '0) begin
        gapCnt <= gapCnt - GAP_W'(1);
      end

      if (iTX_REQ && !oTX_BUSY) begin
        txByte    <= iTX_DATA;
        txPending <= 1'b1;
        oTX_BUSY  <= 1'b1;
      end

      case (state)
        IDLE: begin
          // On a tie the requester not served last goes next.
          if (iRX_REQ && (!txEligible_c || lastTx)) begin
            state             <= RX_RD;
            oJTAG_SLAVE_ADDR  <= JUART_ADDR_DATA;
            oJTAG_SLAVE_RDREQ <= 1'b1;
          end else if (txEligible_c) begin
            state             <= TX_CHK;
            oJTAG_SLAVE_ADDR  <= JUART_ADDR_CTRL;
            oJTAG_SLAVE_RDREQ <= 1'b1;
          end
        end

        RX_RD: begin
          if (!iJTAG_SLAVE_WAIT) begin
            oRX_DATA          <= iJTAG_SLAVE_RDDATA[RXDATA_MSB:0];
            oRX_VALID         <= iJTAG_SLAVE_RDDATA[RVALID_BIT];
            oRX_DONE          <= 1'b1;
            oJTAG_SLAVE_RDREQ <= 1'b0;
            lastTx            <= 1'b0;
            state             <= IDLE;
          end
        end

        TX_CHK: begin
          if (!iJTAG_SLAVE_WAIT) begin
            oJTAG_SLAVE_RDREQ <= 1'b0;
            if (wspaceOf(iJTAG_SLAVE_RDDATA) != 16'h0000) begin
              state              <= TX_WR;
              oJTAG_SLAVE_ADDR   <= JUART_ADDR_DATA;
              oJTAG_SLAVE_WRREQ  <= 1'b1;
              oJTAG_SLAVE_WRDATA <= {24'h000000, txByte};
            end else begin
              // Host FIFO full: back off so RX keeps the bus meanwhile.
              gapCnt           <= GAP_W'(TX_SPACE_RETRY_GAP);
              lastTx           <= 1'b1;
              oJTAG_SLAVE_ADDR <= JUART_ADDR_DATA;
              state            <= IDLE;
            end
          end
        end

        TX_WR: begin
          if (!iJTAG_SLAVE_WAIT) begin
            oJTAG_SLAVE_WRREQ <= 1'b0;
            txPending         <= 1'b0;
            oTX_DONE          <= 1'b1;
            oTX_BUSY          <= 1'b0;
            lastTx            <= 1'b1;
            state             <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_uart_bus_arbiter.sv
// Directed bench for jtag_uart_bus_arbiter: Avalon slave model plus an ordered completion scoreboard.
module tb_jtag_uart_bus_arbiter;

  typedef struct packed {
    logic       isTx;
    logic [7:0] data;
    logic       valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxReq = 1'b0;
  logic        rxDone;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        txReq = 1'b0;
  logic [7:0]  txData = 8'h00;
  logic        txBusy;
  logic        txDone;
  logic        jAddr;
  logic        jRd;
  logic [31:0] jRdData;
  logic        jWr;
  logic [31:0] jWrData;
  logic        jWait = 1'b0;

  int          checks = 0;
  int          errors = 0;
  exp_t        expQ[$];
  logic [31:0] ctrlQ[$];
  logic [31:0] ctrlWord = 32'h0;
  logic [31:0] dataWord = 32'h0;
  int          waitCycles = 0;

  // Slave-model and monitor bookkeeping (negedge process only).
  logic [1:0]  prevCur = 2'b00;
  int          idx = 0;
  logic        popPending = 1'b0;
  logic        prevWaitM = 1'b0;
  logic        prevAddr = 1'b0;
  logic [31:0] prevWrData = 32'h0;
  logic [31:0] lastWrWord = 32'h0;

  always #5 clk = ~clk;

  assign jRdData = jAddr ? ctrlWord : dataWord;

  jtag_uart_bus_arbiter #(.TX_SPACE_RETRY_GAP(16)) dut (
    .iCLK               (clk),
    .iRST               (rst),
    .iRX_REQ            (rxReq),
    .oRX_DONE           (rxDone),
    .oRX_DATA           (rxData),
    .oRX_VALID          (rxValid),
    .iTX_REQ            (txReq),
    .iTX_DATA           (txData),
    .oTX_BUSY           (txBusy),
    .oTX_DONE           (txDone),
    .oJTAG_SLAVE_ADDR   (jAddr),
    .oJTAG_SLAVE_RDREQ  (jRd),
    .iJTAG_SLAVE_RDDATA (jRdData),
    .oJTAG_SLAVE_WRREQ  (jWr),
    .oJTAG_SLAVE_WRDATA (jWrData),
    .iJTAG_SLAVE_WAIT   (jWait)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Avalon slave model, protocol monitor and completion scoreboard.
  always @(negedge clk) begin
    logic [1:0] cur;
    exp_t       e;
    cur = {jWr, jRd};
    if (popPending && ctrlQ.size() != 0) void'(ctrlQ.pop_front());
    popPending = 1'b0;
    if (rst) begin
      idx       = 0;
      jWait     = 1'b0;
      prevCur   = 2'b00;
      prevWaitM = 1'b0;
    end else begin
      idx     = (cur != 2'b00 && cur == prevCur) ? idx + 1 : 0;
      jWait   = (cur != 2'b00) && (idx < waitCycles);
      popPending = jRd && jAddr && !jWait;
      if (cur != 2'b00) begin
        check("rd_wr_exclusive", {31'h0, jRd & jWr}, 32'h0);
        if (prevWaitM && cur == prevCur) begin
          check("addr_stable", {31'h0, jAddr}, {31'h0, prevAddr});
          check("wrdata_stable", jWrData, prevWrData);
        end
      end
      if (jWr && !jWait) lastWrWord = jWrData;
      if (rxDone || txDone) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got rx=%0b tx=%0b want none", rxDone, txDone);
        end else begin
          e = expQ.pop_front();
          if (rxDone) begin
            check("sb_kind_rx", {31'h0, e.isTx}, 32'h0);
            check("sb_rx_data", {24'h0, rxData}, {24'h0, e.data});
            check("sb_rx_valid", {31'h0, rxValid}, {31'h0, e.valid});
          end else begin
            check("sb_kind_tx", {31'h0, e.isTx}, 32'h1);
            check("sb_tx_word", lastWrWord, {24'h0, e.data});
          end
        end
      end
      prevCur    = cur;
      prevWaitM  = jWait;
      prevAddr   = jAddr;
      prevWrData = jWrData;
    end
    ctrlWord = (ctrlQ.size() != 0) ? ctrlQ[0] : 32'h0;
  end

  initial begin
    int n;
    int rxCnt;
    int ctrlCnt;
    int firstChk;
    int lastChk;
    logic seen;

    // Reset state
    repeat (2) tick;
    check("rst_rdreq", {31'h0, jRd}, 32'h0);
    check("rst_wrreq", {31'h0, jWr}, 32'h0);
    check("rst_addr", {31'h0, jAddr}, 32'h0);
    check("rst_wrdata", jWrData, 32'h0);
    check("rst_busy", {31'h0, txBusy}, 32'h0);
    check("rst_dones", {30'h0, rxDone, txDone}, 32'h0);
    check("rst_rxout", {23'h0, rxValid, rxData}, 32'h0);
    rst = 1'b0;
    tick;

    // RX, no wait
    dataWord = 32'h0000_8041;
    expQ.push_back('{isTx: 1'b0, data: 8'h41, valid: 1'b1});
    rxReq = 1'b1;
    tick;
    check("rx0_rdreq", {30'h0, jRd, jAddr}, 32'h2);
    check("rx0_no_done_yet", {31'h0, rxDone}, 32'h0);
    rxReq = 1'b0;
    tick;
    check("rx0_rdreq_drop", {31'h0, jRd}, 32'h0);
    check("rx0_done", {31'h0, rxDone}, 32'h1);
    repeat (2) tick;

    // RX, waitrequest held 3 cycles
    waitCycles = 3;
    dataWord = 32'h0000_0033;
    expQ.push_back('{isTx: 1'b0, data: 8'h33, valid: 1'b0});
    rxReq = 1'b1;
    tick;
    rxReq = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && jRd; i++) begin
      n++;
      tick;
    end
    check("rxw_rdreq_cycles", n, 4);
    check("rxw_done_after_wait", {31'h0, rxDone}, 32'h1);
    waitCycles = 0;
    repeat (2) tick;

    // TX A5 with space available
    ctrlQ.push_back(32'h0040_0000);
    expQ.push_back('{isTx: 1'b1, data: 8'hA5, valid: 1'b0});
    txData = 8'hA5;
    txReq = 1'b1;
    tick;
    check("tx_busy_accept", {31'h0, txBusy}, 32'h1);
    txReq = 1'b0;
    tick;
    check("tx_chk", {29'h0, jWr, jRd, jAddr}, 32'h3);
    tick;
    check("tx_wr", {29'h0, jWr, jRd, jAddr}, 32'h4);
    check("tx_wrdata", jWrData, 32'h0000_00A5);
    tick;
    check("tx_done", {30'h0, txDone, txBusy}, 32'h2);
    tick;
    check("tx_after", {30'h0, txDone, txBusy}, 32'h0);
    tick;

    // TX with WSPACE=0, RX held high through the retry gap
    ctrlQ.push_back(32'h0000_0000);
    ctrlQ.push_back(32'h0001_0000);
    dataWord = 32'h0000_8055;
    for (int i = 0; i < 9; i++) expQ.push_back('{isTx: 1'b0, data: 8'h55, valid: 1'b1});
    expQ.push_back('{isTx: 1'b1, data: 8'h5A, valid: 1'b0});
    txData = 8'h5A;
    txReq = 1'b1;
    rxReq = 1'b1;
    tick;
    txReq = 1'b0;
    rxCnt = 0; ctrlCnt = 0; firstChk = -1; lastChk = -1; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (rxDone) rxCnt++;
      if (jRd && jAddr) begin
        ctrlCnt++;
        if (firstChk < 0) firstChk = i;
        lastChk = i;
      end
      if (txDone) seen = 1'b1;
      else tick;
    end
    rxReq = 1'b0;
    check("gap_tx_done_seen", {31'h0, seen}, 32'h1);
    check("gap_rx_reads", rxCnt, 9);
    check("gap_ctrl_reads", ctrlCnt, 2);
    check("gap_chk_spacing", lastChk - firstChk, 18);
    repeat (3) tick;

    // Tie after reset: RX, TX, RX
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    ctrlQ.push_back(32'h0001_0000);
    dataWord = 32'h0000_0012;
    expQ.push_back('{isTx: 1'b0, data: 8'h12, valid: 1'b0});
    expQ.push_back('{isTx: 1'b1, data: 8'h3C, valid: 1'b0});
    expQ.push_back('{isTx: 1'b0, data: 8'h12, valid: 1'b0});
    txData = 8'h3C;
    txReq = 1'b1;
    rxReq = 1'b1;
    tick;
    txReq = 1'b0;
    rxCnt = 0;
    for (int i = 0; i < 50 && rxCnt < 2; i++) begin
      if (rxDone) rxCnt++;
      if (rxCnt < 2) tick;
    end
    rxReq = 1'b0;
    check("tie_rx_count", rxCnt, 2);
    repeat (3) tick;

    // Reset during TX_WR with waitrequest high
    waitCycles = 5;
    ctrlQ.push_back(32'h0001_0000);
    txData = 8'h77;
    txReq = 1'b1;
    tick;
    txReq = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (jWr) seen = 1'b1;
      else tick;
    end
    check("rstwr_reached_wr", {31'h0, seen}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rstwr_strobes", {30'h0, jWr, jRd}, 32'h0);
    check("rstwr_busy", {31'h0, txBusy}, 32'h0);
    check("rstwr_outs", {jWrData[23:0], jAddr, txDone, rxDone, rxValid, rxData[3:0]}, 32'h0);
    check("rstwr_wrdata_hi", {24'h0, jWrData[31:24]}, 32'h0);
    tick;
    waitCycles = 0;
    rst = 1'b0;
    tick;
    ctrlQ.push_back(32'h0001_0000);
    expQ.push_back('{isTx: 1'b1, data: 8'h99, valid: 1'b0});
    txData = 8'h99;
    txReq = 1'b1;
    tick;
    check("post_rst_accept", {31'h0, txBusy}, 32'h1);
    txReq = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (txDone) seen = 1'b1;
      else tick;
    end
    check("post_rst_tx_done", {31'h0, seen}, 32'h1);
    repeat (3) tick;

    check("sb_drained", expQ.size(), 0);
    check("ctrl_consumed", ctrlQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
